// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
//   deb_state_t            : debounce FSM state encoding
//   DEB_STABLE_CYCLES_DEF  : default acceptance window (1 ms @ 50 MHz)
//   DEB_HOLD_CYCLES_DEF    : default long-press threshold (50 ms @ 50 MHz)
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b10,
        S_FALL = 2'b11
    } deb_state_t;

    localparam int DEB_STABLE_CYCLES_DEF = 50000;
    localparam int DEB_HOLD_CYCLES_DEF   = 2500000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pad level.
// Ports:
//   clk          in   system clock
//   async_reset  in   asynchronous active-high reset, clears both flops
//   d_in         in   asynchronous input level
//   sync_out     out  level synchronised to clk, 2 clk behind d_in
module sync_2ff (
    input  logic clk,
    input  logic async_reset,
    input  logic d_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button level and drives a clean registered level.
// A new level is accepted only after STABLE_CYCLES consecutive agreeing
// synchronised samples; any disagreement restarts the window.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN adds the long_press output,
// asserted once the accepted-high level has lasted HOLD_CYCLES clocks.
// Ports:
//   clk            in   system clock
//   async_reset    in   asynchronous active-high reset
//   signal_input   in   raw button level from pad, 1 = pressed
//   signal_output  out  debounced registered level, 1 = pressed
//   long_press     out  registered long-press flag (DEBOUNCE_LONG_PRESS_EN only)
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
    parameter int HOLD_CYCLES   = DEB_HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic async_reset,
    input  logic signal_input,
    output logic signal_output
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("button_debouncer: STABLE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("button_debouncer: HOLD_CYCLES must be >= 1");
    end

    logic       sync_lvl;
    deb_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       out_q, out_d;

    sync_2ff u_sync (
        .clk         (clk),
        .async_reset (async_reset),
        .d_in        (signal_input),
        .sync_out    (sync_lvl)
    );

    // cnt holds the number of agreeing samples already seen in the current
    // window, so the sample that makes it STABLE_CYCLES is the one that
    // finds cnt == STABLE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            S_LOW: begin
                out_d = 1'b0;
                cnt_d = '0;
                if (sync_lvl) begin
                    state_d = S_RISE;
                    cnt_d   = CNT_ONE;
                end
            end
            S_RISE: begin
                out_d = 1'b0;
                if (!sync_lvl) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    out_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                out_d = 1'b1;
                cnt_d = '0;
                if (!sync_lvl) begin
                    state_d = S_FALL;
                    cnt_d   = CNT_ONE;
                end
            end
            S_FALL: begin
                out_d = 1'b1;
                if (sync_lvl) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                out_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign signal_output = out_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_q, long_d;

    // Counting starts on the first clock after out rose, so long_press
    // lands exactly HOLD_CYCLES clocks after signal_output went high.
    // Keying the clear on out_d lets both flags drop on the falling edge
    // itself; an aborted fall never touches out, so hold_cnt survives it.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_d     = long_q;
        if (!out_d) begin
            hold_cnt_d = '0;
            long_d     = 1'b0;
        end else if (out_q) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
            long_d = (hold_cnt_d == HOLD_MAX);
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
        end
    end

    assign long_press = long_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    logic clk = 1'b0;
    logic async_reset;
    logic signal_input;
    logic signal_output;
`ifdef DEBOUNCE_LONG_PRESS_EN
    logic long_press;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .STABLE_CYCLES (4),
        .HOLD_CYCLES   (10)
    ) dut (
        .clk           (clk),
        .async_reset   (async_reset),
        .signal_input  (signal_input),
        .signal_output (signal_output)
`ifdef DEBOUNCE_LONG_PRESS_EN
        ,
        .long_press    (long_press)
`endif
    );

    typedef struct {
        logic in_lvl;
        logic exp_out;
        logic exp_lp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic i, input logic o, input logic l, input int n);
        vec_t v;
        v.in_lvl  = i;
        v.exp_out = o;
        v.exp_lp  = l;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b required %b", name, act, exp);
    endtask

    task automatic check_outs(input string name, input logic eo, input logic el);
        check({name, ".out"}, signal_output, eo);
`ifdef DEBOUNCE_LONG_PRESS_EN
        check({name, ".lp"}, long_press, el);
`else
        if (el === 1'bx) $display("note: unexpected X in expectation for %s", name);
`endif
    endtask

    // Drive on the falling edge, check 1 time unit after the rising edge.
    task automatic step(input string name, input logic i, input logic eo, input logic el);
        @(negedge clk);
        signal_input = i;
        @(posedge clk);
        #1;
        check_outs(name, eo, el);
    endtask

    task automatic release_and_follow(input string name);
        @(negedge clk);
        async_reset  = 1'b0;
        signal_input = 1'b1;
        @(posedge clk);
        #1;
        check_outs($sformatf("%s.e1", name), 1'b0, 1'b0);
        for (int e = 2; e <= 5; e++) step($sformatf("%s.e%0d", name, e), 1'b1, 1'b0, 1'b0);
        step({name, ".e6"}, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        // press with a one-cycle dropout while high, held into long press
        add(1, 0, 0, 5);
        add(1, 1, 0, 4);
        add(0, 1, 0, 1);
        add(1, 1, 0, 5);
        add(1, 1, 1, 3);
        add(0, 1, 1, 5);
        add(0, 0, 0, 3);
        // bounce 1,0,1,0,1 every 2 cycles then held
        add(1, 0, 0, 2);
        add(0, 0, 0, 2);
        add(1, 0, 0, 2);
        add(0, 0, 0, 2);
        add(1, 0, 0, 5);
        add(1, 1, 0, 3);
        add(0, 1, 0, 5);
        add(0, 0, 0, 2);
        // 3-cycle glitch: rejected
        add(1, 0, 0, 3);
        add(0, 0, 0, 5);
        // 4-cycle pulse: accepted once
        add(1, 0, 0, 4);
        add(0, 0, 0, 1);
        add(0, 1, 0, 4);
        add(0, 0, 0, 3);

        async_reset  = 1'b1;
        signal_input = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_init", 1'b0, 1'b0);
        @(negedge clk);
        async_reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].in_lvl, vecs[i].exp_out, vecs[i].exp_lp);
        end

        // reset asserted mid-clock while output is high
        for (int e = 1; e <= 5; e++) step($sformatf("pre_rst.e%0d", e), 1'b1, 1'b0, 1'b0);
        for (int e = 6; e <= 8; e++) step($sformatf("pre_rst.e%0d", e), 1'b1, 1'b1, 1'b0);
        #2;
        async_reset = 1'b1;
        #1;
        check_outs("rst_immediate", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("rst_held", 1'b0, 1'b0);
        release_and_follow("rst_release");
        for (int r = 1; r <= 5; r++) step($sformatf("rel1.r%0d", r), 1'b0, 1'b1, 1'b0);
        for (int r = 6; r <= 8; r++) step($sformatf("rel1.r%0d", r), 1'b0, 1'b0, 1'b0);

        // reset in the middle of the rise window (cnt = 3)
        for (int e = 1; e <= 5; e++) step($sformatf("mid_win.e%0d", e), 1'b1, 1'b0, 1'b0);
        #2;
        async_reset = 1'b1;
        #1;
        check_outs("mid_win_rst", 1'b0, 1'b0);
        release_and_follow("mid_win_release");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
